// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request port to APB initiator.
// One transfer in flight: SETUP, ACCESS (with wait states), then a held response.
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned PADDR_WIDTH    = 32,
  parameter int unsigned PWDATA_WIDTH   = 32,
  parameter int unsigned PRDATA_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [PADDR_WIDTH-1:0]  req_addr,
  input  logic                    req_write,
  input  logic [PWDATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PRDATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic [PADDR_WIDTH-1:0]  paddr,
  output logic                    prwd,
  output logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic [PRDATA_WIDTH-1:0] prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]              state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic                    prwd_q, prwd_d;
  logic [PWDATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [PRDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_slverr_q, rsp_slverr_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  // Next-state, request capture and response capture.
  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    prwd_d       = prwd_q;
    pwdata_d     = pwdata_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          prwd_d   = req_write;
          pwdata_d = req_wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_rdata_d  = prwd_q ? '0 : prdata;
          rsp_slverr_d = pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  // Phase outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      paddr_q      <= '0;
      prwd_q       <= 1'b0;
      pwdata_q     <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      rsp_valid_q  <= rsp_valid_d;
      paddr_q      <= paddr_d;
      prwd_q       <= prwd_d;
      pwdata_q     <= pwdata_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign rsp_valid  = rsp_valid_q;
  assign paddr      = paddr_q;
  assign prwd       = prwd_q;
  assign pwdata     = pwdata_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table, hand-written corner sequences,
// and randomized transfers against a transfer-level reference model.
module tb_apb_master_bridge;

  localparam int unsigned TO = 4;

  logic        pclock = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, prwd, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  int total = 0;
  int bad   = 0;

  always #5 pclock = ~pclock;

  apb_master_bridge #(
    .PADDR_WIDTH   (32),
    .PWDATA_WIDTH  (32),
    .PRDATA_WIDTH  (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclock     (pclock),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .prwd       (prwd),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int unsigned waits;   // pready low for this many ACCESS cycles
    logic [31:0] prdata;
    logic        perr;
    int unsigned hold;    // cycles rsp_ready stays low in RESP
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int unsigned acc;     // ACCESS cycles (penable high)
  } res_t;

  typedef struct {
    xfer_t x;
    res_t  e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer-level expectation derived from the APB rules.
  function automatic res_t model(input xfer_t x);
    res_t r;
    int unsigned need;
    need = x.waits + 1;
`ifdef APB_MASTER_TIMEOUT_EN
    if (need > TO) begin
      r.rdata = '0; r.err = 1'b1; r.to = 1'b1; r.acc = TO;
      return r;
    end
`endif
    r.rdata = x.wr ? 32'h0 : x.prdata;
    r.err   = x.perr;
    r.to    = 1'b0;
    r.acc   = need;
    return r;
  endfunction

  // Runs one transfer; entered and left at a negedge. lat = negedges from accept to rsp_valid.
  task automatic do_xfer(input xfer_t x, output res_t r, output int unsigned lat);
    bit          done;
    logic [34:0] snap;
    r.rdata = '0; r.err = 1'b0; r.to = 1'b0; r.acc = 0;
    req_valid = 1'b1; req_addr = x.addr; req_write = x.wr; req_wdata = x.wdata;
    rsp_ready = 1'b0;
    chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
    @(posedge pclock); @(negedge pclock);
    // Garbage on the request port and APB inputs must be ignored from here on.
    req_valid = 1'b1; req_addr = $urandom; req_write = 1'(($urandom)); req_wdata = $urandom;
    lat = 1;
    chk("setup_phase", {62'h0, psel, penable}, 64'h2);
    chk("setup_req_ready", {63'h0, req_ready}, 64'h0);
    chk("setup_paddr", {32'h0, paddr}, {32'h0, x.addr});
    pready = 1'b1; prdata = $urandom; pslverr = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge pclock); @(negedge pclock);
      lat++;
      if (rsp_valid) done = 1'b1;
      else begin
        r.acc++;
        chk("access_phase", {62'h0, psel, penable}, 64'h3);
        chk("access_paddr", {32'h0, paddr}, {32'h0, x.addr});
        chk("access_prwd_pwdata", {31'h0, prwd, pwdata}, {31'h0, x.wr, x.wdata});
        if (r.acc == x.waits + 1) begin
          pready = 1'b1; prdata = x.prdata; pslverr = x.perr;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'(($urandom));
        end
      end
    end
    chk("rsp_wait_bound", {63'h0, done}, 64'h1);
    pready = 1'b1; prdata = $urandom; pslverr = 1'(($urandom));
    r.rdata = rsp_rdata; r.err = rsp_slverr; r.to = rsp_timeout;
    snap = {rsp_rdata, rsp_slverr, rsp_timeout, rsp_valid};
    chk("resp_phase", {61'h0, psel, penable, req_ready}, 64'h0);
    for (int h = 0; h < int'(x.hold); h++) begin
      @(posedge pclock); @(negedge pclock);
      chk("resp_hold", {29'h0, rsp_rdata, rsp_slverr, rsp_timeout, rsp_valid}, {29'h0, snap});
      chk("resp_hold_req_ready", {63'h0, req_ready}, 64'h0);
    end
    rsp_ready = 1'b1;
    @(posedge pclock); @(negedge pclock);
    rsp_ready = 1'b0; req_valid = 1'b0; pready = 1'b0;
    chk("release_valid_ready", {62'h0, rsp_valid, req_ready}, 64'h1);
    chk("idle_paddr_kept", {32'h0, paddr}, {32'h0, x.addr});
  endtask

  task automatic run_and_check(input string tag, input xfer_t x, input res_t e);
    res_t        r;
    int unsigned lat;
    do_xfer(x, r, lat);
    chk({tag, "_rdata"}, {32'h0, r.rdata}, {32'h0, e.rdata});
    chk({tag, "_slverr"}, {63'h0, r.err}, {63'h0, e.err});
    chk({tag, "_timeout"}, {63'h0, r.to}, {63'h0, e.to});
    chk({tag, "_access_cycles"}, 64'(r.acc), 64'(e.acc));
    chk({tag, "_latency"}, 64'(lat), 64'(e.acc + 2));
  endtask

  vec_t  vecs[6];
  xfer_t xr;
  res_t  er;

  initial begin
    vecs[0] = '{x: '{32'h10, 1'b1, 32'hDEADBEEF, 0, 32'h1234, 1'b0, 0}, e: '{32'h0, 1'b0, 1'b0, 1}};
    vecs[1] = '{x: '{32'h20, 1'b0, 32'h0, 3, 32'hCAFEF00D, 1'b0, 0}, e: '{32'hCAFEF00D, 1'b0, 1'b0, 4}};
    vecs[2] = '{x: '{32'h24, 1'b0, 32'h0, 1, 32'h55AA, 1'b1, 5}, e: '{32'h55AA, 1'b1, 1'b0, 2}};
    vecs[3] = '{x: '{32'h30, 1'b1, 32'h12345678, 2, 32'hFFFF, 1'b1, 2}, e: '{32'h0, 1'b1, 1'b0, 3}};
    vecs[4] = '{x: '{32'hFFFFFFFC, 1'b0, 32'h0, 0, 32'hFFFFFFFF, 1'b0, 1}, e: '{32'hFFFFFFFF, 1'b0, 1'b0, 1}};
    vecs[5] = '{x: '{32'h0, 1'b1, 32'h0, 0, 32'hA5A5A5A5, 1'b0, 0}, e: '{32'h0, 1'b0, 1'b0, 1}};

    preset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1;
    chk("reset_outputs", {58'h0, psel, penable, prwd, rsp_valid, rsp_slverr, rsp_timeout}, 64'h0);
    chk("reset_buses", {paddr, pwdata}, 64'h0);
    chk("reset_rdata", {32'h0, rsp_rdata}, 64'h0);
    chk("reset_req_ready", {63'h0, req_ready}, 64'h1);
    @(negedge pclock); @(negedge pclock);
    preset = 1'b0;
    @(negedge pclock);

    for (int i = 0; i < 6; i++) run_and_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].e);

    // Reset asserted mid-ACCESS: outputs drop at once and no response follows.
    req_valid = 1'b1; req_addr = 32'h40; req_write = 1'b0; req_wdata = '0;
    @(posedge pclock); @(negedge pclock);
    req_valid = 1'b0; pready = 1'b0;
    @(posedge pclock); @(negedge pclock);
    chk("pre_reset_access", {62'h0, psel, penable}, 64'h3);
    #1 preset = 1'b1;
    #1;
    chk("reset_mid_access", {61'h0, psel, penable, rsp_valid}, 64'h0);
    chk("reset_mid_req_ready", {63'h0, req_ready}, 64'h1);
    pready = 1'b1; prdata = 32'hBAD0BAD0;
    @(negedge pclock);
    preset = 1'b0; pready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge pclock); @(negedge pclock);
      chk("post_reset_quiet", {61'h0, psel, penable, rsp_valid}, 64'h0);
    end
    pready = 1'b0;
    xr = '{32'h44, 1'b0, 32'h0, 1, 32'h0BADF00D, 1'b0, 0};
    run_and_check("after_reset", xr, '{32'h0BADF00D, 1'b0, 1'b0, 2});

`ifdef APB_MASTER_TIMEOUT_EN
    xr = '{32'h50, 1'b0, 32'h0, 1000, 32'h11111111, 1'b0, 1};
    run_and_check("timeout_abort", xr, '{32'h0, 1'b1, 1'b1, 4});
    xr = '{32'h54, 1'b0, 32'h0, 3, 32'h22222222, 1'b0, 0};
    run_and_check("timeout_edge_win", xr, '{32'h22222222, 1'b0, 1'b0, 4});
`endif

    for (int i = 0; i < 40; i++) begin
      xr.addr   = $urandom;
      xr.wr     = 1'(($urandom));
      xr.wdata  = $urandom;
      xr.waits  = $urandom_range(0, 6);
      xr.prdata = $urandom;
      xr.perr   = ($urandom_range(0, 3) == 0);
      xr.hold   = $urandom_range(0, 3);
      er = model(xr);
      run_and_check($sformatf("rand%0d", i), xr, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
